// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall controller with multi-cycle divider sequencing.
//
// Purpose:
//   Launches the iterative divider when EX holds a div/divu, holds the front
//   of the pipeline (PC .. EX/MEM) while the divide runs, and raises a
//   one-cycle div_done when the result is ready.  A 7-bit watchdog forces
//   completion after 64 BUSY cycles without div_ready and sets a sticky
//   div_timeout flag.  Load-use hazards from ID produce the lighter ID
//   stall pattern when no divide stall is active.
//
// Ports:
//   clk             in   pipeline clock
//   rst             in   synchronous active-high reset
//   stallreq_id     in   load-use hazard request from ID
//   ex_div_req      in   EX holds a div/divu instruction
//   ex_div_signed   in   1 = div, 0 = divu (valid with ex_div_req)
//   div_ready       in   divider result-valid pulse (ignored outside BUSY)
//   div_start       out  one-cycle divider launch pulse
//   div_signed      out  latched sign mode of the running divide
//   div_done        out  one-cycle pulse: EX captures quotient/remainder
//   div_timeout     out  sticky watchdog flag, cleared only by rst
//   stall[5:0]      out  per-stage hold, 1 = stop:
//                        bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
//                        bit4 MEM/WB, bit5 WB
//   perf_stall_cnt  out  count of cycles with stall[0]=1
//
// Handshake: div_start is a single-cycle strobe issued in the cycle EX
//   presents ex_div_req in IDLE; the divider answers with a single-cycle
//   div_ready while this block is BUSY.  A div_ready at any other time is
//   dropped.  div_done is a single-cycle strobe one cycle after acceptance.
//
// Configuration:
//   PIPE_CTRL_PERF_EN  when defined, perf_stall_cnt is a saturating 32-bit
//                      counter; otherwise it is tied to 0 with no register.

module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_div_req,
  input  logic        ex_div_signed,
  input  logic        div_ready,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_done,
  output logic        div_timeout,
  output logic [5:0]  stall,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [6:0] WD_LIMIT   = 7'd64;

  state_e     state_q, state_d;
  logic [6:0] wd_q, wd_d;
  logic       div_signed_q, div_signed_d;
  logic       div_timeout_q, div_timeout_d;
  logic       ex_stall;

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wd_q          <= wd_d;
    div_signed_q  <= div_signed_d;
    div_timeout_q <= div_timeout_d;
  end

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    div_signed_d  = div_signed_q;
    div_timeout_d = div_timeout_q;
    div_start     = 1'b0;
    div_done      = 1'b0;
    ex_stall      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_div_req) begin
          div_start    = 1'b1;
          ex_stall     = 1'b1;
          div_signed_d = ex_div_signed;
          wd_d         = 7'd0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        ex_stall = 1'b1;
        wd_d     = wd_q + 7'd1;
        if (div_ready) begin
          state_d = DONE;
        end else if (wd_d == WD_LIMIT) begin
          // 64th BUSY cycle with no result: force completion.
          state_d       = DONE;
          div_timeout_d = 1'b1;
        end
      end
      DONE: begin
        // ex_div_req is ignored here so div_start can never follow a
        // previous launch back-to-back.
        div_done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset overrides everything, including the combinational strobes, so
    // a divide abandoned in BUSY produces no div_done.
    if (rst) begin
      state_d       = IDLE;
      wd_d          = 7'd0;
      div_signed_d  = 1'b0;
      div_timeout_d = 1'b0;
      div_start     = 1'b0;
      div_done      = 1'b0;
      ex_stall      = 1'b0;
    end
  end

  // EX pattern wins over the ID pattern; both act in the request cycle.
  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      if (ex_stall) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end
    end
  end

  assign div_signed  = div_signed_q;
  assign div_timeout = div_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (rst) begin
      perf_d = 32'd0;
    end else if (stall[0] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, pipeline clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port stallreq_id, input, 1, load-use hazard request from ID.
REQ-004 SHALL have port ex_div_req, input, 1, high while EX holds a div/divu instruction.
REQ-005 SHALL have port ex_div_signed, input, 1, 1 = div, 0 = divu, valid with ex_div_req.
REQ-006 SHALL have port div_ready, input, 1, divider result-valid pulse.
REQ-007 SHALL have port div_start, output, 1, one-cycle divider launch pulse.
REQ-008 SHALL have port div_signed, output, 1, latched sign mode for the running divide.
REQ-009 SHALL have port div_done, output, 1, one-cycle pulse telling EX to capture the quotient and remainder.
REQ-010 SHALL have port div_timeout, output, 1, sticky flag set when the watchdog fires.
REQ-011 SHALL have port stall, output, 6, per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-012 SHALL have port perf_stall_cnt, output, 32, stall-cycle counter (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE with ex_div_req=1 SHALL assert div_start for that cycle, latch ex_div_signed into div_signed, and go to BUSY.
REQ-015 BUSY with div_ready=1 SHALL go to DONE; otherwise it SHALL stay in BUSY.
REQ-016 DONE SHALL assert div_done for exactly one cycle, ignore ex_div_req, and go to IDLE.
REQ-017 stall SHALL be 6'b001111 in IDLE when ex_div_req=1, and in every BUSY cycle (EX pattern).
REQ-018 Otherwise, stall SHALL be 6'b000111 when stallreq_id=1 (ID pattern; ID/EX inserts a bubble).
REQ-019 Otherwise, stall SHALL be 6'b000000; this includes DONE with stallreq_id=0.
REQ-020 The EX pattern SHALL take priority over the ID pattern in any simultaneous case.
REQ-021 stall SHALL be combinational from state and inputs, so a stall takes effect in the request cycle.
REQ-022 A 7-bit watchdog SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-023 When the watchdog reaches 64 without div_ready, the FSM SHALL go to DONE and set div_timeout.
REQ-024 div_timeout SHALL remain set until rst.
REQ-025 A div_ready received in IDLE or DONE SHALL be ignored.
REQ-026 div_start SHALL never be asserted in two consecutive cycles.

Reset
REQ-027 On rst the FSM SHALL enter IDLE, and the watchdog and perf_stall_cnt SHALL clear.
REQ-028 On rst, div_start, div_signed, div_done and div_timeout SHALL be 0, and stall SHALL be 6'b000000 while rst is high.
REQ-029 rst asserted in BUSY SHALL abandon the divide with no div_done pulse.

Configuration
REQ-030 With macro PIPE_CTRL_PERF_EN defined, perf_stall_cnt SHALL increment on every cycle where stall[0]=1.
REQ-031 With PIPE_CTRL_PERF_EN defined, perf_stall_cnt SHALL saturate at 32'hFFFFFFFF and not wrap.
REQ-032 Without PIPE_CTRL_PERF_EN, perf_stall_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-033 ex_div_req=1, ex_div_signed=1 in IDLE, then div_ready 32 cycles later -> div_start=1 in cycle 0, div_signed=1, and stall=6'b001111 for cycles 0..32; div_done=1 and stall=0 in cycle 33.
REQ-034 stallreq_id=1 for 1 cycle in IDLE, with no div request -> stall=6'b000111 for that cycle only, with no FSM change.
REQ-035 stallreq_id=1 during BUSY -> stall=6'b001111; stallreq_id=1 in DONE -> stall=6'b000111 with div_done=1.
REQ-036 BUSY with no div_ready for 64 cycles -> DONE on the 65th cycle, div_done=1 and div_timeout=1; div_timeout stays 1 until rst.
REQ-037 rst pulsed in BUSY cycle 10 -> next cycle IDLE, stall=0, and no div_done; a later div_ready is ignored.
REQ-038 With PIPE_CTRL_PERF_EN defined, two 32-cycle divides plus 3 ID stalls -> perf_stall_cnt=69; without the macro -> perf_stall_cnt=0.
